// File: rtl/router_fifo.sv
// router_fifo: per-destination output buffer of the 1x3 router.
// Stores WIDTH-bit bytes tagged with a header flag (bit WIDTH of each entry).
// It tracks the remaining packet length on the read side and is flushed by a
// soft reset from the read-timeout logic.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-low reset
//   soft_reset  synchronous, active-high flush (lower priority than rst)
//   write_enb   write request for this instance
//   read_enb    read request from the output port
//   lfd_state   high when data_in is the header byte
//   data_in     byte to store
//   data_out    registered read data
//   full        no free entry
//   empty       no stored entry
module router_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  logic [WIDTH:0]   mem_q [DEPTH];
  logic [WIDTH:0]   mem_d [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [6:0]       pkt_count_q, pkt_count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;

  logic             wr_ok;
  logic             rd_ok;
  logic [WIDTH:0]   rd_entry;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  assign wr_ok    = write_enb && !full;
  assign rd_ok    = read_enb && !empty;
  assign rd_entry = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign data_out = data_out_q;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pkt_count_d = pkt_count_q;
    data_out_d  = data_out_q;

    if (soft_reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_d[i] = '0;
      end
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      pkt_count_d = '0;
      data_out_d  = '0;
    end else begin
      if (wr_ok) begin
        mem_d[wr_ptr_q[PTR_W-1:0]] = {lfd_state, data_in};
        wr_ptr_d = wr_ptr_q + 1'b1;
      end

      if (rd_ok) begin
        data_out_d = rd_entry[WIDTH-1:0];
        rd_ptr_d   = rd_ptr_q + 1'b1;
        // Header byte carries payload length in [7:2]; +1 covers the parity byte.
        if (rd_entry[WIDTH]) begin
          pkt_count_d = {1'b0, rd_entry[7:2]} + 7'd1;
        end else if (pkt_count_q != '0) begin
          pkt_count_d = pkt_count_q - 7'd1;
        end
      end else if (pkt_count_q == '0) begin
        data_out_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pkt_count_q <= '0;
      data_out_q  <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pkt_count_q <= pkt_count_d;
      data_out_q  <= data_out_d;
    end
  end

endmodule
